// File: rtl/mem_lanes_clr.sv
// Tagged lane memory with valid/ready port, 1/2-cycle read latency and clear sequencer.
// Optional MEM_LANES_SIM_X_EN: X-drive idle response outputs and flag X control inputs.
module mem_lanes_clr #(
   parameter int ADDR_WIDTH     = 8,
   parameter int LANES          = 4,
   parameter int LANE_BITS      = 8,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [LANES-1:0]             req_wmask,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   input  logic [LANES*LANE_BITS-1:0]   req_wdata,
   input  logic                         req_wgrubby,
   input  logic                         clear_req,
   output logic                         busy,
   output logic                         rsp_valid,
   output logic [LANES*LANE_BITS-1:0]   rsp_rdata,
   output logic                         rsp_rgrubby
);
   localparam int SIZE = 1 << ADDR_WIDTH;
   localparam int DW   = LANES * LANE_BITS;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] clr_cnt, cnt_nx;
   logic                  accept, wr_acc, rd_acc;
   logic [LANES-1:0]      we;
   logic [ADDR_WIDTH-1:0] wa;
   logic [DW-1:0]         wd;
   logic                  wt;
   logic [DW-1:0]         mem [SIZE];
   logic [LANES-1:0]      tag_mem [SIZE];
   logic [DW-1:0]         rd_data;
   logic                  rd_tag;
   logic                  s_valid;
   logic [DW-1:0]         s_data;
   logic                  s_tag;
   logic [DW-1:0]         rdata_q;
   logic                  tag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = clr_cnt;
      busy      = 1'b0;
      req_ready = 1'b0;
      unique case (state)
         S_CLEAR: begin
            busy   = 1'b1;
            cnt_nx = clr_cnt + 1'b1;
            if (&clr_cnt) state_nx = S_RUN;
         end
         S_RUN: begin
            req_ready = ~clear_req & ~rst;
            if (clear_req) begin
               cnt_nx   = '0;
               state_nx = S_CLEAR;
            end
         end
         default: state_nx = S_RUN;
      endcase
   end

   assign accept = req_valid & req_ready;
   assign wr_acc = accept & req_write;
   assign rd_acc = accept & ~req_write;

   // The clear sequencer owns the single write port while busy.
   always_comb begin
      we = wr_acc ? req_wmask : '0;
      wa = req_addr;
      wd = req_wdata;
      wt = req_wgrubby;
      if (busy) begin
         we = '1;
         wa = clr_cnt;
         wd = '0;
         wt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) begin
            mem[wa][i*LANE_BITS +: LANE_BITS] <= wd[i*LANE_BITS +: LANE_BITS];
            tag_mem[wa][i] <= wt;
         end
      end
   end

   assign rd_data = mem[req_addr];
   assign rd_tag  = |tag_mem[req_addr];

   if (READ_LATENCY >= 2) begin : g_lat2
      logic          p_valid;
      logic [DW-1:0] p_data;
      logic          p_tag;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            p_valid <= 1'b0;
            p_data  <= '0;
            p_tag   <= 1'b0;
         end else begin
            p_valid <= rd_acc;
            if (rd_acc) begin
               p_data <= rd_data;
               p_tag  <= rd_tag;
            end
         end
      end
      assign s_valid = p_valid;
      assign s_data  = p_data;
      assign s_tag   = p_tag;
   end else begin : g_lat1
      assign s_valid = rd_acc;
      assign s_data  = rd_data;
      assign s_tag   = rd_tag;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rdata_q   <= '0;
         tag_q     <= 1'b0;
      end else begin
         rsp_valid <= s_valid;
         if (s_valid) begin
            rdata_q <= s_data;
            tag_q   <= s_tag;
         end
      end
   end

`ifdef MEM_LANES_SIM_X_EN
   assign rsp_rdata   = rsp_valid ? rdata_q : 'x;
   assign rsp_rgrubby = rsp_valid ? tag_q : 1'bx;

   always @(posedge clk) begin
      if (!rst && req_valid !== 1'b0 &&
          $isunknown({req_valid, req_write, req_wmask, req_addr, clear_req}))
         $display("ERROR mem_lanes_clr: X on request control at %0t", $time);
   end
`else
   assign rsp_rdata   = rdata_q;
   assign rsp_rgrubby = tag_q;
`endif

endmodule

// File: tb/tb_mem_lanes_clr.sv
// Directed bench for mem_lanes_clr: latency-1 and latency-2 instances share stimulus.
module tb_mem_lanes_clr;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [3:0]  req_wmask;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        req_wgrubby;
   logic        clear_req;
   logic        rdy1, rdy2, busy1, busy2, v1, v2, g1, g2;
   logic [31:0] d1, d2;
   int          checks = 0;
   int          errors = 0;
   int          n, nv, nb;

   always #5 clk = ~clk;

   mem_lanes_clr #(.ADDR_WIDTH(4), .LANES(4), .LANE_BITS(8),
                   .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
      .req_write(req_write), .req_wmask(req_wmask), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wgrubby(req_wgrubby),
      .clear_req(clear_req), .busy(busy1), .rsp_valid(v1),
      .rsp_rdata(d1), .rsp_rgrubby(g1));

   mem_lanes_clr #(.ADDR_WIDTH(4), .LANES(4), .LANE_BITS(8),
                   .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2),
      .req_write(req_write), .req_wmask(req_wmask), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wgrubby(req_wgrubby),
      .clear_req(clear_req), .busy(busy2), .rsp_valid(v2),
      .rsp_rdata(d2), .rsp_rgrubby(g2));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Counts negedges with busy high (bounded), plus stray ready/rsp samples.
   task automatic wait_clear(output int nbusy, output int nvalid,
                             output int nrdy);
      nbusy = 0; nvalid = 0; nrdy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (v1 || v2) nvalid++;
         if (!busy1) break;
         if (rdy1 || rdy2 || !busy2) nrdy++;
         nbusy++;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic g);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = a;
      req_wdata = d; req_wmask = m; req_wgrubby = g;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [3:0] a,
                     input logic [31:0] ed, input logic eg);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      @(negedge clk);
      check({tag, "_rdy"}, 64'(rdy1), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, "_v1"}, 64'(v1), 64'd1);
      check({tag, "_d1"}, 64'(d1), 64'(ed));
      check({tag, "_g1"}, 64'(g1), 64'(eg));
      check({tag, "_v2early"}, 64'(v2), 64'd0);
      @(negedge clk);
      check({tag, "_v1pulse"}, 64'(v1), 64'd0);
      check({tag, "_v2"}, 64'(v2), 64'd1);
      check({tag, "_d2"}, 64'(d2), 64'(ed));
      check({tag, "_g2"}, 64'(g2), 64'(eg));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wmask = '0;
      req_addr = '0; req_wdata = '0; req_wgrubby = 1'b0; clear_req = 1'b0;
      #23;
      check("rst_rdy", 64'(rdy1 | rdy2), 64'd0);
      check("rst_busy", 64'({busy1, busy2}), 64'h3);
      check("rst_v", 64'(v1 | v2), 64'd0);
      check("rst_d", 64'(d1 | d2), 64'd0);
      check("rst_g", 64'(g1 | g2), 64'd0);

      @(posedge clk); #1 rst = 1'b0;
      wait_clear(n, nv, nb);
      check("clr_len", 64'(n), 64'd16);
      check("clr_rdy", 64'(nb), 64'd0);
      check("clr_v", 64'(nv), 64'd0);
      check("run_busy", 64'(busy2), 64'd0);

      rd("rd5", 4'd5, 32'h0, 1'b0);

      wr(4'd3, 32'hDEADBEEF, 4'b1111, 1'b0);
      rd("full", 4'd3, 32'hDEADBEEF, 1'b0);

      wr(4'd3, 32'h0000AA00, 4'b0010, 1'b1);
      rd("part", 4'd3, 32'hDEADAAEF, 1'b1);

      wr(4'd3, 32'hFFFFFFFF, 4'b0000, 1'b0);
      rd("nomask", 4'd3, 32'hDEADAAEF, 1'b1);

      wr(4'd1, 32'h11, 4'b1111, 1'b0);
      wr(4'd2, 32'h22, 4'b1111, 1'b0);
      wr(4'd3, 32'h33, 4'b1111, 1'b0);
      // reads of 1,2,3 back to back
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd1;
      @(negedge clk);
      check("pipe_n0_v2", 64'(v2), 64'd0);
      @(posedge clk); #1 req_addr = 4'd2;
      @(negedge clk);
      check("pipe_n1_v2", 64'(v2), 64'd0);
      check("pipe_n1_d1", 64'({v1, d1}), {31'd0, 1'b1, 32'h11});
      @(posedge clk); #1 req_addr = 4'd3;
      @(negedge clk);
      check("pipe_n2_d2", 64'({v2, d2}), {31'd0, 1'b1, 32'h11});
      check("pipe_n2_d1", 64'({v1, d1}), {31'd0, 1'b1, 32'h22});
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("pipe_n3_d2", 64'({v2, d2}), {31'd0, 1'b1, 32'h22});
      check("pipe_n3_d1", 64'({v1, d1}), {31'd0, 1'b1, 32'h33});
      @(negedge clk);
      check("pipe_n4_d2", 64'({v2, d2}), {31'd0, 1'b1, 32'h33});
      check("pipe_n4_v1", 64'(v1), 64'd0);
      @(negedge clk);
      check("pipe_hold", 64'({v2, d2}), {31'd0, 1'b0, 32'h33});

      // clear request beats a simultaneous read
      @(posedge clk); #1;
      clear_req = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
      @(negedge clk);
      check("rtclr_rdy", 64'(rdy1 | rdy2), 64'd0);
      @(posedge clk); #1;
      clear_req = 1'b0; req_valid = 1'b0;
      wait_clear(n, nv, nb);
      check("rtclr_len", 64'(n), 64'd16);
      check("rtclr_v", 64'(nv), 64'd0);
      check("rtclr_rdy_busy", 64'(nb), 64'd0);
      rd("rtclr_rd3", 4'd3, 32'h0, 1'b0);

      wr(4'd4, 32'h12345678, 4'b1111, 1'b1);
      rd("pre_abort", 4'd4, 32'h12345678, 1'b1);

      @(posedge clk); #1 clear_req = 1'b1;
      @(posedge clk); #1 clear_req = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_d", 64'(d1 | d2), 64'd0);
      check("abort_g", 64'(g1 | g2), 64'd0);
      check("abort_rdy", 64'(rdy1 | rdy2), 64'd0);
      check("abort_busy", 64'({busy1, busy2}), 64'h3);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_clear(n, nv, nb);
      check("abort_len", 64'(n), 64'd16);
      rd("post_abort", 4'd4, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_lanes_clr.md
Name: mem_lanes_clr

Overview:
- Parametrised single-port tagged memory: LANES byte-style lanes of LANE_BITS data plus one grubby tag bit per lane.
- Adds three things over the fixed-width RAM primitives:
  - a valid/ready request port;
  - selectable read latency (1 or 2);
  - a hardware clear sequencer that zeroes every word after reset or on demand.
- Replaces the fixed Memory9/Memory4x9/Memory36 usage wherever contents cannot be pre-initialised.

Parameters:
- ADDR_WIDTH, 8, word address bits; depth SIZE = 1 << ADDR_WIDTH.
- LANES, 4, number of byte lanes per word.
- LANE_BITS, 8, data bits per lane; data width DW = LANES*LANE_BITS.
- READ_LATENCY, 1, cycles from accepted read to rsp_valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1: run clear sequence after reset release; 0: enter RUN directly.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid&ready.
- req_write  input  1  1 = write, 0 = read.
- req_wmask  input  LANES  per-lane write enable.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DW  write data; lane i = bits [i*LANE_BITS +: LANE_BITS].
- req_wgrubby  input  1  tag value written to every enabled lane.
- clear_req  input  1  pulse in RUN starts a full clear.
- busy  output  1  clear sequence in progress.
- rsp_valid  output  1  one-cycle pulse, read data valid.
- rsp_rdata  output  DW  read data.
- rsp_rgrubby  output  1  OR of all lane tags of the word read.

Behaviour:
- Reset (async):
  - State = CLEAR with counter 0 if CLEAR_ON_RESET, else RUN.
  - rsp_valid = 0, rsp_rdata = 0, rsp_rgrubby = 0.
  - busy = CLEAR_ON_RESET.
  - req_ready = 0 while rst is high.
  - Memory array is not reset.
- State CLEAR:
  - Each cycle writes zero data and zero tags to address clr_cnt, then increments.
  - After address SIZE-1 is written, moves to RUN next cycle. The sequence takes exactly SIZE cycles.
  - busy = 1 and req_ready = 0 throughout.
- State RUN:
  - busy = 0; req_ready = ~clear_req (combinational).
  - clear_req high in RUN: counter := 0, state := CLEAR next cycle. No request is accepted in that cycle.
  - clear_req is ignored in CLEAR.
- Accepted write (valid & ready & write):
  - For each lane i with wmask[i]=1: data lane := wdata lane, tag[i] := req_wgrubby.
  - Lanes with wmask[i]=0 are unchanged.
  - wmask = 0 is a no-op.
  - A write produces no response.
- Accepted read:
  - rsp_valid pulses exactly READ_LATENCY cycles later.
  - rsp_rdata = stored data; rsp_rgrubby = OR of the LANES tags.
- Back-to-back reads: one per cycle, full throughput; responses are in order.
- Write followed immediately by a read of the same address returns the new data (the write committed on the earlier edge).
- Response outputs:
  - rsp_rdata/rsp_rgrubby hold their last value when rsp_valid = 0.
  - Responses already in the read pipeline complete even if clear starts.
- Reset mid-clear aborts; after release the clear restarts from address 0.
- Reset also flushes the read pipeline; in-flight responses are dropped.
- Address wrap: none internal; req_addr is always exactly ADDR_WIDTH bits.

Optional Feature:
- MEM_LANES_SIM_X_EN defined (simulation builds):
  - rsp_rdata and rsp_rgrubby are driven to all-X in every cycle where rsp_valid = 0.
  - A request with req_valid=1 and any X on control inputs triggers $display error.
- Undefined (synthesis): outputs hold their last value as specified; no checks.

Test Plan:
- ADDR_WIDTH=4, CLEAR_ON_RESET=1, release rst:
  - busy=1 and req_ready=0 for exactly 16 cycles, then busy=0.
  - Read addr 5 -> rsp_rdata=0x00000000, rsp_rgrubby=0.
- Full write then read: write addr 3, data 0xDEADBEEF, wmask 1111, wgrubby 0; read addr 3 -> 0xDEADBEEF, rgrubby 0, rsp_valid exactly 1 cycle after accept (READ_LATENCY=1).
- Partial write then read: write addr 3, data 0x0000AA00, wmask 0010, wgrubby 1; read addr 3 -> 0xDEADAAEF, rgrubby 1.
- Pipelined reads: READ_LATENCY=2, reads of addr 1,2,3 on consecutive cycles after writing 0x11,0x22,0x33 -> rsp_valid high 3 consecutive cycles starting 2 cycles after first accept, data 0x11,0x22,0x33 in order.
- Runtime clear: clear_req pulse with req_valid=1 in the same cycle:
  - Request is not accepted.
  - busy high 16 cycles.
  - Read addr 3 afterwards -> 0, rgrubby 0.
- Reset abort: assert rst when clr_cnt=7 -> outputs zero immediately; after release busy high a full 16 cycles again.
